voice_mixer: RTL and testbench
==============================

# voice_mixer

Downstream stage of the per-voice envelope/CC controller. It consumes one enveloped signed 16-bit sample per voice per frame and sums all voices of a frame in a wide accumulator. The frame total is attenuated by an arithmetic right shift, saturated to 16 bits, and queued in a 2-entry output buffer. The DAC/serializer drains that buffer through a valid/ready handshake.

## Interface
Parameters:
- NUM_VOICES, 32: voices per frame. Legal range 1..128; voice indices 0..NUM_VOICES-1.
- SHIFT, 3: attenuation right shift applied to the frame total. Legal range 0..7.
- ACC_STATE, 2'd3: value of i_pipeline_state during which i_sample/i_voice_index are valid from the upstream stage.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  reset, asynchronous, active-low.
- i_voice_index  in  8  voice currently presented by the controller.
- i_pipeline_state  in  2  shared voice pipeline phase.
- i_sample  in  16 signed  enveloped sample for i_voice_index.
- i_mix_ready  in  1  consumer accepts the head of the buffer.
- o_mix_sample  out  16 signed  buffer head; 0 when empty.
- o_mix_valid  out  1  buffer non-empty.
- o_clip  out  1  one-cycle pulse when a pushed frame was saturated.
- o_overrun  out  1  sticky; a completed frame was dropped because the buffer was full.

## Operation
- **Capture strobe.** Asserted in a cycle where i_pipeline_state == ACC_STATE and the previous cycle's state != ACC_STATE.
  - Captures exactly once per entry into ACC_STATE, however long the state is held.
  - The previous-state flag resets to "was in ACC_STATE", so a fresh entry is required after reset.
- **Out-of-range index.** A strobe with i_voice_index >= NUM_VOICES is ignored.
- **Accumulator.** 24-bit signed, with sign-extended addition.
  - On a strobe with index 0, the accumulator loads i_sample. This starts a new frame and discards any partial sum.
  - On a strobe with another valid index, the accumulator adds i_sample.
  - Index order is not checked and duplicate indices are summed.
- **Frame complete.** Occurs on a strobe with index NUM_VOICES-1. The sum is that cycle's accumulate result: the loaded value if NUM_VOICES == 1, otherwise acc + i_sample.
  - Result = sum >>> SHIFT (arithmetic).
  - Saturate: values > 32767 become 32767 and values < -32768 become -32768. Either case pulses o_clip, but only if the frame is pushed.
  - The accumulator clears to 0 in the same cycle.
- **Output buffer.** 2-entry FIFO.
  - Pop when o_mix_valid && i_mix_ready.
  - Push on frame complete.
  - When full, a push succeeds only if a pop occurs in the same cycle.
  - Otherwise the new frame is dropped, o_overrun sets and o_clip stays 0.
  - Output order is push order.
- **o_overrun.** Cleared only by reset.
- **Reset (any time, including mid-frame).**
  - Accumulator = 0, buffer empty.
  - o_mix_sample = 0, o_mix_valid = 0, o_clip = 0, o_overrun = 0.
  - Previous-state flag = in ACC_STATE.
  - A partially accumulated frame is lost. If upstream resumes mid-frame, the next completed frame contains only the voices seen since reset.

## Timing
- **Strobe cycle N.** The accumulator holds the new value at cycle N+1.
- **Frame complete at cycle N.**
  - The entry is in the buffer at N+1.
  - If the buffer was empty, o_mix_valid = 1 and o_mix_sample = result at N+1.
  - o_clip is high during N+1 only.
  - Input-to-output latency is one cycle.
- **Handshake.** The consumer samples o_mix_sample when o_mix_valid && i_mix_ready at a rising edge. The next entry, if any, appears in the following cycle.
- **Output stability.** o_mix_valid and o_mix_sample are registered and do not depend combinationally on i_mix_ready.
- **Throughput.** One voice per strobe, so a strobe needs at least one non-ACC_STATE cycle between captures. The buffer sustains one frame per cycle in and out.

## Test plan
- **Basic sum.** NUM_VOICES=4, SHIFT=0; strobes for voices 0..3 with 100, 200, -50, 7 -> o_mix_sample=257, o_mix_valid=1 one cycle after voice 3; o_clip stays 0.
- **Saturation.** SHIFT=0; four voices of 30000 -> 32767 with a one-cycle o_clip. Four voices of -30000 -> -32768 with o_clip. SHIFT=2 with four voices of -3 -> -3.
- **Held state.** ACC_STATE held 3 cycles per voice, each voice sample 1000 -> single capture per voice, result 4000.
- **Backpressure.** i_mix_ready=0; frames with results 1, 2, 3 -> buffer holds 1, 2; 3 is dropped; o_overrun=1. Then i_mix_ready=1 -> outputs 1, then 2, then o_mix_valid=0; o_overrun stays 1.
- **Push/pop same cycle.** Buffer full (1, 2), i_mix_ready=1 in the frame-complete cycle for 3 -> 1 popped, 3 accepted, no overrun; subsequent outputs 2, 3.
- **Reset mid-frame.** Reset after voices 0, 1 (10, 20) -> all outputs 0. Upstream continues with voices 2, 3 (30, 40) on fresh ACC_STATE entries -> result 70. An index-5 strobe with NUM_VOICES=4 is ignored.

Source files
------------

// File: rtl/voice_mixer.sv
// voice_mixer
//   Sums one enveloped signed 16-bit sample per voice into a 24-bit frame
//   accumulator. On the last voice of a frame, the total is arithmetically
//   shifted right by SHIFT, saturated to 16 bits and pushed into a 2-entry
//   output buffer. A valid/ready consumer drains that buffer.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          asynchronous reset, active low
//   i_voice_index    voice presented by the upstream controller
//   i_pipeline_state shared pipeline phase; capture happens on entry to ACC_STATE
//   i_sample         enveloped sample for i_voice_index
//   i_mix_ready      consumer accepts the buffer head
//   o_mix_sample     buffer head (0 when the buffer is empty)
//   o_mix_valid      buffer is non-empty
//   o_clip           one-cycle pulse when a pushed frame was saturated
//   o_overrun        sticky; a completed frame was dropped on a full buffer
module voice_mixer #(
  parameter int         NUM_VOICES = 32,
  parameter int         SHIFT      = 3,
  parameter logic [1:0] ACC_STATE  = 2'd3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_voice_index,
  input  logic [1:0]         i_pipeline_state,
  input  logic signed [15:0] i_sample,
  input  logic               i_mix_ready,
  output logic signed [15:0] o_mix_sample,
  output logic               o_mix_valid,
  output logic               o_clip,
  output logic               o_overrun
);

  // Registered state
  logic               in_acc_q;     // previous cycle was in ACC_STATE
  logic signed [23:0] acc_q;
  logic signed [15:0] head_q;       // buffer entry presented to the consumer
  logic signed [15:0] tail_q;       // second buffer entry
  logic [1:0]         count_q;      // number of buffered entries, 0..2
  logic               clip_q;
  logic               overrun_q;

  // Next-state values
  logic signed [23:0] acc_d;
  logic signed [15:0] head_d;
  logic signed [15:0] tail_d;
  logic [1:0]         count_d;
  logic               clip_d;
  logic               overrun_d;

  // Combinational intermediates
  logic               in_acc;
  logic               strobe;
  logic               idx_ok;
  logic               capture;
  logic               is_first;
  logic               is_last;
  logic               frame_done;
  logic signed [23:0] sample_ext;
  logic signed [23:0] acc_sum;
  logic signed [23:0] shifted;
  logic               saturated;
  logic signed [15:0] result;
  logic               pop;
  logic               push;

  always_comb begin
    in_acc     = (i_pipeline_state == ACC_STATE);
    // Capture only on the first cycle of each visit to ACC_STATE.
    strobe     = in_acc && !in_acc_q;
    idx_ok     = ({1'b0, i_voice_index} < 9'(NUM_VOICES));
    capture    = strobe && idx_ok;
    is_first   = (i_voice_index == 8'd0);
    is_last    = (i_voice_index == 8'(NUM_VOICES - 1));
    frame_done = capture && is_last;

    sample_ext = {{8{i_sample[15]}}, i_sample};
    // Index 0 starts a fresh frame, dropping any stale partial sum.
    acc_sum    = is_first ? sample_ext : (acc_q + sample_ext);

    shifted    = acc_sum >>> SHIFT;
    // The shifted value fits in 16 bits only if bits 23..15 all agree.
    saturated  = !((&shifted[23:15]) || !(|shifted[23:15]));
    if (saturated) begin
      result = shifted[23] ? 16'sh8000 : 16'sh7fff;
    end else begin
      result = shifted[15:0];
    end

    pop  = (count_q != 2'd0) && i_mix_ready;
    // A full buffer still accepts a frame when the head leaves this cycle.
    push = frame_done && ((count_q != 2'd2) || pop);
  end

  // Accumulator next state
  always_comb begin
    acc_d = acc_q;
    if (frame_done) begin
      acc_d = '0;
    end else if (capture) begin
      acc_d = acc_sum;
    end
  end

  // Output buffer next state: pop first, then push into the freed slot.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    clip_d    = 1'b0;
    overrun_d = overrun_q;

    if (pop) begin
      // Head reads as 0 once the buffer drains.
      head_d  = (count_q == 2'd2) ? tail_q : 16'sd0;
      tail_d  = 16'sd0;
      count_d = count_q - 2'd1;
    end

    if (push) begin
      if (count_d == 2'd0) begin
        head_d = result;
      end else begin
        tail_d = result;
      end
      count_d = count_d + 2'd1;
      clip_d  = saturated;
    end else if (frame_done) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      // Require a fresh entry into ACC_STATE after reset.
      in_acc_q  <= 1'b1;
      acc_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      in_acc_q  <= in_acc;
      acc_q     <= acc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_mix_sample = head_q;
  assign o_mix_valid  = (count_q != 2'd0);
  assign o_clip       = clip_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Testbench for voice_mixer. Two instances share the same stimulus:
// instance A uses SHIFT=0 and instance B uses SHIFT=2, both with NUM_VOICES=4.
// A queue-based reference model predicts both instances every cycle.
// Table-driven frame vectors and hand-written sequences add explicit checks.
module tb_voice_mixer;

  localparam int NV = 4;
  localparam logic [1:0] ACC = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] idx;
  logic [1:0] state;
  logic signed [15:0] sample;
  logic ready;

  logic signed [15:0] out_a, out_b;
  logic valid_a, valid_b, clip_a, clip_b, ovr_a, ovr_b;

  always #5 clk = ~clk;

  voice_mixer #(.NUM_VOICES(NV), .SHIFT(0), .ACC_STATE(ACC)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_voice_index(idx), .i_pipeline_state(state),
    .i_sample(sample), .i_mix_ready(ready), .o_mix_sample(out_a),
    .o_mix_valid(valid_a), .o_clip(clip_a), .o_overrun(ovr_a));

  voice_mixer #(.NUM_VOICES(NV), .SHIFT(2), .ACC_STATE(ACC)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_voice_index(idx), .i_pipeline_state(state),
    .i_sample(sample), .i_mix_ready(ready), .o_mix_sample(out_b),
    .o_mix_valid(valid_b), .o_clip(clip_b), .o_overrun(ovr_b));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_acc = 0;
  bit m_prev = 1'b1;
  int q_a[$];
  int q_b[$];
  bit m_ovr_a = 0, m_ovr_b = 0, m_clip_a = 0, m_clip_b = 0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int sat16(int v, output bit c);
    c = 1'b0;
    if (v > 32767) begin c = 1'b1; return 32767; end
    if (v < -32768) begin c = 1'b1; return -32768; end
    return v;
  endfunction

  // Predict the effect of the coming clock edge given the current inputs.
  task automatic model_step();
    bit pop_a, pop_b, done, c;
    int sum, r;
    if (!rst_n) begin
      m_acc = 0; m_prev = 1'b1;
      q_a.delete(); q_b.delete();
      m_ovr_a = 0; m_ovr_b = 0; m_clip_a = 0; m_clip_b = 0;
      return;
    end
    pop_a = (q_a.size() > 0) && ready;
    pop_b = (q_b.size() > 0) && ready;
    m_clip_a = 0; m_clip_b = 0;
    done = 0; sum = 0;
    if (state == ACC && !m_prev && int'(idx) < NV) begin
      sum = (idx == 0) ? int'(sample) : m_acc + int'(sample);
      if (int'(idx) == NV - 1) begin done = 1; m_acc = 0; end
      else m_acc = sum;
    end
    m_prev = (state == ACC);
    if (pop_a) void'(q_a.pop_front());
    if (pop_b) void'(q_b.pop_front());
    if (done) begin
      r = sat16(sum, c);
      if (q_a.size() < 2) begin q_a.push_back(r); m_clip_a = c; end
      else m_ovr_a = 1;
      r = sat16(sum >>> 2, c);
      if (q_b.size() < 2) begin q_b.push_back(r); m_clip_b = c; end
      else m_ovr_b = 1;
    end
  endtask

  // Inputs are set during the low phase; one clock edge; compare afterwards.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("A_valid",   int'(valid_a), int'(q_a.size() > 0));
    chk("A_sample",  int'(out_a),   (q_a.size() > 0) ? q_a[0] : 0);
    chk("A_clip",    int'(clip_a),  int'(m_clip_a));
    chk("A_overrun", int'(ovr_a),   int'(m_ovr_a));
    chk("B_valid",   int'(valid_b), int'(q_b.size() > 0));
    chk("B_sample",  int'(out_b),   (q_b.size() > 0) ? q_b[0] : 0);
    chk("B_clip",    int'(clip_b),  int'(m_clip_b));
    chk("B_overrun", int'(ovr_b),   int'(m_ovr_b));
    @(negedge clk);
  endtask

  task automatic voice(int v, int s);
    state = ACC; idx = 8'(v); sample = 16'(s);
    step();
    state = 2'd0;
    step();
  endtask

  // Runs a frame; returns just after the voice-3 strobe edge.
  task automatic frame(int s0, int s1, int s2, int s3, bit last_ready);
    voice(0, s0); voice(1, s1); voice(2, s2);
    state = ACC; idx = 8'd3; sample = 16'(s3); ready = last_ready;
    step();
    state = 2'd0;
  endtask

  task automatic idle();
    state = 2'd0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; state = 2'd0;
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int s0, s1, s2, s3;
    int exp_a; bit clip_a;
    int exp_b; bit clip_b;
  } vec_t;

  initial begin
    vec_t tbl[7];
    tbl[0] = '{100, 200, -50, 7, 257, 0, 64, 0};
    tbl[1] = '{30000, 30000, 30000, 30000, 32767, 1, 30000, 0};
    tbl[2] = '{-30000, -30000, -30000, -30000, -32768, 1, -30000, 0};
    tbl[3] = '{-3, -3, -3, -3, -12, 0, -3, 0};
    tbl[4] = '{32767, 32767, 32767, 32767, 32767, 1, 32767, 0};
    tbl[5] = '{-32768, -32768, -32768, -32768, -32768, 1, -32768, 0};
    tbl[6] = '{32767, 1, 0, 0, 32767, 1, 8192, 0};

    rst_n = 1'b0; state = 2'd0; idx = '0; sample = '0; ready = 1'b1;
    @(negedge clk);
    do_reset();
    chk("reset_valid", int'(valid_a), 0);
    chk("reset_overrun", int'(ovr_a), 0);
    idle();

    // Table-driven frames with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      frame(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3, 1'b1);
      chk("tbl_A_sample", int'(out_a), tbl[i].exp_a);
      chk("tbl_A_clip",   int'(clip_a), int'(tbl[i].clip_a));
      chk("tbl_B_sample", int'(out_b), tbl[i].exp_b);
      chk("tbl_B_clip",   int'(clip_b), int'(tbl[i].clip_b));
      idle();
      chk("tbl_A_clip_pulse", int'(clip_a), 0);
    end

    // Held ACC_STATE: one capture per visit.
    ready = 1'b0;
    for (int v = 0; v < NV; v++) begin
      state = ACC; idx = 8'(v); sample = 16'sd1000;
      for (int k = 0; k < 3; k++) step();
      idle();
    end
    chk("held_A_sample", int'(out_a), 4000);
    chk("held_B_sample", int'(out_b), 1000);
    ready = 1'b1; idle();

    // Backpressure with overrun.
    ready = 1'b0;
    frame(1, 0, 0, 0, 1'b0); idle();
    frame(2, 0, 0, 0, 1'b0); idle();
    frame(3, 0, 0, 0, 1'b0);
    chk("bp_overrun", int'(ovr_a), 1);
    chk("bp_head1", int'(out_a), 1);
    idle();
    ready = 1'b1;
    idle();
    chk("bp_head2", int'(out_a), 2);
    idle();
    chk("bp_empty", int'(valid_a), 0);
    chk("bp_sticky", int'(ovr_a), 1);

    // Reset mid-frame.
    voice(0, 10); voice(1, 20);
    do_reset();
    chk("rst_sample", int'(out_a), 0);
    chk("rst_overrun", int'(ovr_a), 0);
    idle();
    voice(2, 30);
    state = ACC; idx = 8'd3; sample = 16'sd40;
    step();
    chk("rst_A_result", int'(out_a), 70);
    chk("rst_B_result", int'(out_b), 17);
    idle();

    // Push and pop in the same cycle on a full buffer.
    ready = 1'b0;
    frame(1, 0, 0, 0, 1'b0); idle();
    frame(2, 0, 0, 0, 1'b0); idle();
    frame(3, 0, 0, 0, 1'b1);
    chk("pp_overrun", int'(ovr_a), 0);
    chk("pp_head2", int'(out_a), 2);
    idle();
    chk("pp_head3", int'(out_a), 3);
    idle();
    chk("pp_empty", int'(valid_a), 0);

    // Out-of-range index is ignored.
    voice(0, 5); voice(5, 1000); voice(1, 5); voice(2, 5);
    state = ACC; idx = 8'd3; sample = 16'sd5;
    step();
    chk("oor_A_result", int'(out_a), 20);
    idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      state  = 2'($urandom_range(0, 3));
      idx    = 8'($urandom_range(0, 5));
      sample = 16'($urandom);
      ready  = ($urandom_range(0, 3) != 0);
      rst_n  = ($urandom_range(0, 149) != 0);
      step();
      rst_n  = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
